alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Control and result stage wrapped around the ALU's per-bit 8:1 result mux bank. It accepts one operation request at a time over a valid/ready handshake and holds the operands and the 3-bit `SEL` steady for a programmable settle time. It then captures the bank's `RESULT` and the datapath `CARRY` into an output register, computes Z/N/C/V flags, and presents them over a second valid/ready handshake. It sits between the operand/opcode source and the ALU datapath, and owns the `SEL` lines of every result mux.

## Interface
- `WIDTH`, 4: operand/result width in bits (≥2).
- `SETTLE_CYCLES`, 1: cycles `SEL`/operands are held before capture (≥1; 0 is illegal).

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `IN_VALID` in 1: request valid.
- `IN_READY` out 1: block can accept a request.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `OP` in 3: opcode.
- `SEL` out 3: registered opcode, driven to every result mux.
- `MUX_A` out WIDTH: latched A, driven to the datapath.
- `MUX_B` out WIDTH: latched B, driven to the datapath.
- `RESULT` in WIDTH: result mux bank output.
- `CARRY` in 1: datapath carry, or shifted-out bit for shift ops.
- `OUT_VALID` out 1: result/flags valid.
- `OUT_READY` in 1: consumer accepts the result.
- `R` out WIDTH: registered result.
- `Z`, `N`, `C`, `V` out 1 each: registered flags.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOT A (logic).
  - 100 ADD, 101 SUB (arithmetic).
  - 110 SHL A, 111 SHR A (shift).
- FSM states are IDLE, SETTLE and DONE.
- IDLE:
  - `IN_READY`=1.
  - On `IN_VALID`&`IN_READY`: register `A`→`MUX_A`, `B`→`MUX_B`, `OP`→`SEL`, load the settle counter with `SETTLE_CYCLES`-1, go to SETTLE.
- SETTLE:
  - `IN_READY`=0; the counter decrements each cycle.
  - At the edge where the counter is 0: capture `RESULT`→`R` and compute flags, set `OUT_VALID`=1, go to DONE.
- DONE:
  - `OUT_VALID`=1; `R` and flags are frozen.
  - `SEL`/`MUX_A`/`MUX_B` are held.
  - On `OUT_READY`: clear `OUT_VALID` and go to IDLE.
  - A new request is never accepted in the same cycle as `OUT_READY`.
- Flags are computed from `RESULT`, `CARRY`, and the latched `MUX_A`/`MUX_B`/`SEL`:
  - Z = (`RESULT`==0).
  - N = `RESULT`[WIDTH-1].
  - C = `CARRY` for opcodes 100–111, else 0.
  - V (ADD) = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - V (SUB) = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - V = 0 for all other opcodes.
- Reset values: state IDLE; `SEL`=000; `MUX_A`=`MUX_B`=0; `R`=0; `Z`=`N`=`C`=`V`=0; `OUT_VALID`=0. `IN_READY`=0 while `RST` is high.
- Reset mid-operation (SETTLE or DONE):
  - The operation is discarded; `OUT_VALID` is not asserted for it.
  - All registers take their reset values on that edge.
- `IN_VALID` while busy is ignored. The source must hold `A`/`B`/`OP` until `IN_READY`.
- `RESULT`/`CARRY` changes outside the capture edge have no effect on `R` or the flags.

## Timing
- Accept edge k. `SEL`/`MUX_*` are valid after edge k.
- Capture happens at edge k+`SETTLE_CYCLES`. `OUT_VALID` is high from then on.
- Latency is `SETTLE_CYCLES` cycles from accept to `OUT_VALID`.
- Minimum occupancy per op is `SETTLE_CYCLES`+2 cycles: settle, one DONE cycle with `OUT_READY`=1, one IDLE cycle.
- `IN_READY` is 1 the cycle after the `OUT_READY` handshake edge.
- All outputs are registered, except `IN_READY`, which is decoded from the state and `RST`.
- The datapath must settle `RESULT`/`CARRY` within `SETTLE_CYCLES` clock periods of a `SEL`/`MUX_*` change.

## Structure
- Package `alu_pkg`:
  - Opcode localparams: `OP_AND` … `OP_SHR`.
  - FSM state encoding: `ST_IDLE`, `ST_SETTLE`, `ST_DONE`.
  - Shared by the datapath for `SEL` decoding.
- Settle counter width is $clog2(`SETTLE_CYCLES`+1).
- One combinational sub-module, `alu_flag_gen`:
  - Inputs: `RESULT`, `CARRY`, `SEL`, `MUX_A` msb, `MUX_B` msb.
  - Outputs: next Z/N/C/V.
  - Reused by the verification model.

## Test plan
WIDTH=4, SETTLE_CYCLES=1 unless noted.
- ADD overflow: A=0111, B=0001, OP=100; bench drives `RESULT`=1000, `CARRY`=0 → `OUT_VALID` 1 cycle after accept; `R`=1000, Z=0, N=1, C=0, V=1.
- SUB zero: A=0011, B=0011, OP=101; `RESULT`=0000, `CARRY`=1 → `R`=0000, Z=1, N=0, C=1, V=0.
- Logic masks flags: OP=000 with `CARRY` forced to 1 and `RESULT`=1010 → C=0, V=0, N=1, Z=0.
- Backpressure: `OUT_READY`=0 for 5 cycles while `RESULT` toggles and a second `IN_VALID` is asserted → `R`/flags stable, `IN_READY`=0, second request is accepted only after the handshake plus one IDLE cycle.
- Settle timing, SETTLE_CYCLES=3: `RESULT` changes at accept+1 and accept+2 → `R` equals the value present at edge accept+3; `OUT_VALID` rises at accept+3.
- Reset mid-SETTLE, SETTLE_CYCLES=3: `RST` pulsed at accept+1 → `OUT_VALID` never rises; `SEL`=000, `R`=0; `IN_READY`=1 in the first cycle after `RST` is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU op sequencer and the result mux datapath.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Arithmetic and shift opcodes all live in the upper half of the opcode space.
    function automatic logic op_uses_carry(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, datapath and result signals of the ALU op sequencer; slave is the sequencer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OP;
    logic [2:0]       SEL;
    logic [WIDTH-1:0] MUX_A;
    logic [WIDTH-1:0] MUX_B;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] R;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport slave (
        input  IN_VALID, A, B, OP, RESULT, CARRY, OUT_READY,
        output IN_READY, SEL, MUX_A, MUX_B, OUT_VALID, R, Z, N, C, V
    );

    modport master (
        output IN_VALID, A, B, OP, RESULT, CARRY, OUT_READY,
        input  IN_READY, SEL, MUX_A, MUX_B, OUT_VALID, R, Z, N, C, V
    );

endinterface

// File: rtl/alu_op_sequencer_flag_gen.sv
// Combinational Z/N/C/V generation from the mux bank result and the latched operand signs.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    input  logic [2:0]       sel_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o
);

    logic r_msb;

    assign r_msb = result_i[WIDTH-1];
    assign z_o   = (result_i == '0);
    assign n_o   = r_msb;
    assign c_o   = op_uses_carry(sel_i) ? carry_i : 1'b0;

    // Signed overflow: result sign disagrees with A when the operand signs make it impossible.
    always_comb begin
        v_o = 1'b0;
        case (sel_i)
            OP_ADD:  v_o = (a_msb_i == b_msb_i) && (r_msb != a_msb_i);
            OP_SUB:  v_o = (a_msb_i != b_msb_i) && (r_msb != a_msb_i);
            default: v_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Holds SEL/operands for a settle window, then captures RESULT and flags behind a valid/ready output.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RST,
    alu_op_sequencer_if.slave  bus
);

    localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] mux_a_q, mux_a_d;
    logic [WIDTH-1:0] mux_b_q, mux_b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready;
    logic             z_nx, n_nx, c_nx, v_nx;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result_i (bus.RESULT),
        .carry_i  (bus.CARRY),
        .sel_i    (sel_q),
        .a_msb_i  (mux_a_q[WIDTH-1]),
        .b_msb_i  (mux_b_q[WIDTH-1]),
        .z_o      (z_nx),
        .n_o      (n_nx),
        .c_o      (c_nx),
        .v_o      (v_nx)
    );

    assign in_ready = (state_q == ST_IDLE) && !RST;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mux_a_d     = mux_a_q;
        mux_b_d     = mux_b_q;
        r_d         = r_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.IN_VALID && in_ready) begin
                    sel_d   = bus.OP;
                    mux_a_d = bus.A;
                    mux_b_d = bus.B;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    r_d         = bus.RESULT;
                    z_d         = z_nx;
                    n_d         = n_nx;
                    c_d         = c_nx;
                    v_d         = v_nx;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // Returning through IDLE guarantees no accept on the OUT_READY edge.
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= OP_AND;
            mux_a_q     <= '0;
            mux_b_q     <= '0;
            r_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mux_a_q     <= mux_a_d;
            mux_b_q     <= mux_b_d;
            r_q         <= r_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.SEL       = sel_q;
    assign bus.MUX_A     = mux_a_q;
    assign bus.MUX_B     = mux_b_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.R         = r_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Two sequencers (settle 1 and 3) driven by directed and random transactions against a behavioural ALU model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, iv, cy_s, ordy;
    logic [1:0][W-1:0] a_s, b_s, res_s;
    logic [1:0][2:0]   op_s;

    logic [1:0]        irdy_w, ov_w;
    logic [1:0][2:0]   sel_w;
    logic [1:0][W-1:0] ma_w, mb_w, r_w;
    logic [1:0][3:0]   fl_w;

    int n_cmp = 0;
    int n_mis = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_op_sequencer_if #(.WIDTH(W)) bus ();
        assign bus.IN_VALID  = iv[g];
        assign bus.A         = a_s[g];
        assign bus.B         = b_s[g];
        assign bus.OP        = op_s[g];
        assign bus.RESULT    = res_s[g];
        assign bus.CARRY     = cy_s[g];
        assign bus.OUT_READY = ordy[g];
        assign irdy_w[g]     = bus.IN_READY;
        assign ov_w[g]       = bus.OUT_VALID;
        assign sel_w[g]      = bus.SEL;
        assign ma_w[g]       = bus.MUX_A;
        assign mb_w[g]       = bus.MUX_B;
        assign r_w[g]        = bus.R;
        assign fl_w[g]       = {bus.Z, bus.N, bus.C, bus.V};

        alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .CLK (clk),
            .RST (rst[g]),
            .bus (bus)
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What a correct ALU datapath would present on RESULT for the latched operands.
    function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SHL:  return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    // Carry-out / no-borrow / shifted-out bit; logic ops get a random carry to exercise masking.
    function automatic logic model_carry(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return (int'(a) + int'(b)) > 15;
            OP_SUB:  return int'(a) >= int'(b);
            OP_SHL:  return a[W-1];
            OP_SHR:  return a[0];
            default: return 1'($urandom);
        endcase
    endfunction

    function automatic int as_signed(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - 16 : int'(x);
    endfunction

    // Expected {Z,N,C,V} from the flag rules using signed integer views of A, B and RESULT.
    function automatic logic [3:0] exp_flags(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] r, input logic cy);
        int  sa, sb, sr;
        logic z, n, c, v;
        sa = as_signed(a);
        sb = as_signed(b);
        sr = as_signed(r);
        z  = (r == '0);
        n  = (sr < 0);
        c  = (op == OP_ADD || op == OP_SUB || op == OP_SHL || op == OP_SHR) ? cy : 1'b0;
        v  = 1'b0;
        if (op == OP_ADD) v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        if (op == OP_SUB) v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        return {z, n, c, v};
    endfunction

    task automatic txn(input int d, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res_fin, input logic cy_fin, input int hold, input logic poke);
        int         s;
        logic [3:0] fl;
        s  = (d == 0) ? 1 : 3;
        fl = exp_flags(op, a, b, res_fin, cy_fin);
        check_val("idle_ready", 32'(irdy_w[d]), 32'd1);
        iv[d]    = 1'b1;
        a_s[d]   = a;
        b_s[d]   = b;
        op_s[d]  = op;
        ordy[d]  = 1'b0;
        res_s[d] = 4'($urandom);
        cy_s[d]  = 1'($urandom);
        tick();
        iv[d] = poke;
        if (poke) begin
            a_s[d]  = 4'($urandom);
            b_s[d]  = 4'($urandom);
            op_s[d] = 3'($urandom);
        end
        check_val("acc_sel", 32'(sel_w[d]), 32'(op));
        check_val("acc_mux_a", 32'(ma_w[d]), 32'(a));
        check_val("acc_mux_b", 32'(mb_w[d]), 32'(b));
        check_val("acc_ov", 32'(ov_w[d]), 32'd0);
        check_val("acc_busy", 32'(irdy_w[d]), 32'd0);
        for (int i = 1; i < s; i++) begin
            res_s[d] = 4'($urandom);
            cy_s[d]  = 1'($urandom);
            tick();
            check_val("settle_ov", 32'(ov_w[d]), 32'd0);
            check_val("settle_busy", 32'(irdy_w[d]), 32'd0);
        end
        res_s[d] = res_fin;
        cy_s[d]  = cy_fin;
        tick();
        check_val("cap_ov", 32'(ov_w[d]), 32'd1);
        check_val("cap_r", 32'(r_w[d]), 32'(res_fin));
        check_val("cap_flags", 32'(fl_w[d]), 32'(fl));
        for (int h = 0; h < hold; h++) begin
            res_s[d] = 4'($urandom);
            cy_s[d]  = 1'($urandom);
            iv[d]    = 1'b1;
            a_s[d]   = 4'($urandom);
            op_s[d]  = op ^ 3'b001;
            tick();
            check_val("hold_ov", 32'(ov_w[d]), 32'd1);
            check_val("hold_r", 32'(r_w[d]), 32'(res_fin));
            check_val("hold_flags", 32'(fl_w[d]), 32'(fl));
            check_val("hold_busy", 32'(irdy_w[d]), 32'd0);
            check_val("hold_sel", 32'(sel_w[d]), 32'(op));
        end
        ordy[d] = 1'b1;
        iv[d]   = poke;
        tick();
        ordy[d] = 1'b0;
        iv[d]   = 1'b0;
        check_val("hs_ov", 32'(ov_w[d]), 32'd0);
        check_val("hs_idle", 32'(irdy_w[d]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         cy;
        rst   = 2'b11;
        iv    = '0;
        ordy  = '0;
        cy_s  = '0;
        a_s   = '0;
        b_s   = '0;
        res_s = '0;
        op_s  = '0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check_val("rst_ready_low", 32'(irdy_w[d]), 32'd0);
            check_val("rst_ov", 32'(ov_w[d]), 32'd0);
            check_val("rst_sel", 32'(sel_w[d]), 32'd0);
            check_val("rst_mux_a", 32'(ma_w[d]), 32'd0);
            check_val("rst_mux_b", 32'(mb_w[d]), 32'd0);
            check_val("rst_r", 32'(r_w[d]), 32'd0);
            check_val("rst_flags", 32'(fl_w[d]), 32'd0);
        end
        rst = 2'b00;
        #1;
        check_val("rel_ready0", 32'(irdy_w[0]), 32'd1);
        check_val("rel_ready1", 32'(irdy_w[1]), 32'd1);

        txn(0, OP_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 0, 1'b0);
        txn(0, OP_SUB, 4'b0011, 4'b0011, 4'b0000, 1'b1, 0, 1'b0);
        txn(0, OP_AND, 4'b1010, 4'b1111, 4'b1010, 1'b1, 0, 1'b0);
        txn(0, OP_XOR, 4'b1100, 4'b0101, 4'b1001, 1'b1, 5, 1'b1);
        txn(0, OP_SHL, 4'b1001, 4'b0000, 4'b0010, 1'b1, 1, 1'b0);
        txn(1, OP_ADD, 4'b0101, 4'b0110, 4'b1011, 1'b0, 0, 1'b0);
        txn(1, OP_SUB, 4'b1000, 4'b0001, 4'b0111, 1'b1, 2, 1'b1);

        // Reset pulsed one edge after accept discards the operation.
        check_val("mid_idle", 32'(irdy_w[1]), 32'd1);
        iv[1]   = 1'b1;
        a_s[1]  = 4'b0110;
        b_s[1]  = 4'b0011;
        op_s[1] = OP_SUB;
        tick();
        iv[1] = 1'b0;
        check_val("mid_acc_sel", 32'(sel_w[1]), 32'(OP_SUB));
        rst[1] = 1'b1;
        tick();
        check_val("mid_rst_ready_low", 32'(irdy_w[1]), 32'd0);
        rst[1] = 1'b0;
        #1;
        check_val("mid_ready", 32'(irdy_w[1]), 32'd1);
        check_val("mid_sel", 32'(sel_w[1]), 32'd0);
        check_val("mid_r", 32'(r_w[1]), 32'd0);
        check_val("mid_mux_a", 32'(ma_w[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            res_s[1] = 4'($urandom);
            tick();
            check_val("mid_ov", 32'(ov_w[1]), 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            op  = 3'($urandom);
            a   = 4'($urandom);
            b   = 4'($urandom);
            res = model_result(op, a, b);
            cy  = model_carry(op, a, b);
            txn(t % 2, op, a, b, res, cy, $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
